down_counter_timer: RTL

- Loadable, prescaled down counter: the decrementing counterpart of the lab up-counter, used as a programmable countdown timer alongside the clock divider.
- Counts a loaded value down to zero at a prescaled tick rate, pulses Done at terminal count, and supports pause/resume and auto-reload.
- Decrement datapath is a ripple chain of half-subtractors, the mirror of the half-adder incrementer.

---
 rtl/down_counter_timer_pkg.sv | 17 +
 rtl/down_counter_timer_decrementer.sv | 40 ++++
 rtl/down_counter_timer.sv | 92 +++++++++
 3 files changed

// File: rtl/down_counter_timer_pkg.sv
// Shared state encoding and sizing helpers for the countdown timer.
// No logic; constants only.
// No flow control.
package down_counter_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    // Prescaler register width; a divide-by-1 still needs one bit to exist.
    function automatic int presc_width(input int presc);
        return (presc > 1) ? $clog2(presc) : 1;
    endfunction

endpackage

// File: rtl/down_counter_timer_decrementer.sv
// Ripple decrementer built from half-subtractor cells.
// Combinational, zero latency.
// No flow control.
module half_subtractor (
    input  logic A,
    input  logic B,
    output logic D,
    output logic Bo
);
    assign D  = A ^ B;
    assign Bo = ~A & B;
endmodule

module n_bit_decrementer #(
    parameter int WIDTH = 8
) (
    output logic [WIDTH-1:0] Diff,
    output logic             BorrowOut,
    input  logic [WIDTH-1:0] Count,
    input  logic             En
);
    logic [WIDTH:0] borrow;

    // En acts as the borrow-in, so En=0 passes Count through unchanged.
    assign borrow[0] = En;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_cell
            half_subtractor u_hs (
                .A  (Count[i]),
                .B  (borrow[i]),
                .D  (Diff[i]),
                .Bo (borrow[i+1])
            );
        end
    endgenerate

    assign BorrowOut = borrow[WIDTH];
endmodule

// File: rtl/down_counter_timer.sv
// Loadable prescaled countdown timer with pause/resume and auto-reload.
// Count/Done registered; Done pulses the cycle after the terminal tick.
// No backpressure; Load > Stop > Start > tick priority each edge.
module down_counter_timer
    import down_counter_timer_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             Start,
    input  logic             Stop,
    input  logic             AutoReload,
    output logic [WIDTH-1:0] Count,
    output logic             Done,
    output logic             Busy
);
    localparam int            PW       = presc_width(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    state_t           state;
    logic [WIDTH-1:0] reload;
    logic [PW-1:0]    pre;
    logic [WIDTH-1:0] dec_diff;
    logic             dec_borrow;
    logic             tick;
    logic             last;

    n_bit_decrementer #(.WIDTH(WIDTH)) u_dec (
        .Diff      (dec_diff),
        .BorrowOut (dec_borrow),
        .Count     (Count),
        .En        (1'b1)
    );

    assign tick = (pre == PRE_LAST);
    assign last = (Count == WIDTH'(1));
    assign Busy = (state != IDLE);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Count  <= '0;
            reload <= '0;
            pre    <= '0;
            Done   <= 1'b0;
            state  <= IDLE;
        end else begin
            Done <= 1'b0;
            if (Load) begin
                Count  <= LoadVal;
                reload <= LoadVal;
                pre    <= '0;
                state  <= IDLE;
            end else if (Stop && state != IDLE) begin
                state <= PAUSE;
            end else if (Start && state == IDLE) begin
                if (Count != '0) begin
                    state <= RUN;
                    pre   <= '0;
                end
            end else if (Start && state == PAUSE) begin
                state <= RUN;
            end else if (state == RUN) begin
                if (tick) begin
                    pre <= '0;
                    if (last) begin
                        Done <= 1'b1;
                        // reload is never zero here: a zero count cannot be started.
                        if (AutoReload) begin
                            Count <= reload;
                        end else begin
                            Count <= '0;
                            state <= IDLE;
                        end
                    end else begin
                        Count <= dec_diff;
                    end
                end else begin
                    pre <= pre + PW'(1);
                end
            end
        end
    end

    // A running count is never zero, so the decrementer must never borrow out.
    assert property (@(posedge Clk) disable iff (!Rst_n)
        (state == RUN && tick && !Load && !Stop) |-> !dec_borrow);

endmodule
